// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: controller states
// and operation mode encodings.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell, used as the serial bit slice.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C,
   output logic Sum,
   output logic Cout
);

   assign Sum  = A ^ B ^ C;
   assign Cout = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first,
// WIDTH cycles per operation with a registered one-cycle done strobe.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] shr_q, shr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] shr_next;

   full_adder u_cell (
      .A    (opa_q[0]),
      .B    (opb_q[0]),
      .C    (carry_q),
      .Sum  (fa_sum),
      .Cout (fa_cout)
   );

   // Shift right with the new sum bit entering at the MSB; also valid for WIDTH=1.
   assign shr_next = (shr_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      shr_d   = shr_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      idx_d   = idx_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = (sub == MODE_SUB) ? ~b : b;
               carry_d = sub;
               idx_d   = '0;
               shr_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            opa_d   = opa_q >> 1;
            opb_d   = opb_q >> 1;
            shr_d   = shr_next;
            carry_d = fa_cout;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               // Results are written on the final step so they appear with done;
               // carry_q here is the carry into the MSB.
               sum_d   = shr_next;
               cout_d  = fa_cout;
               ovf_d   = carry_q ^ fa_cout;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         shr_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         shr_q   <= shr_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         idx_q   <= idx_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed scoreboard bench for serial_addsub at WIDTH=8 and WIDTH=1.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       busy, done, cout, ovf;
   logic [7:0] sum;

   logic       start1, sub1;
   logic [0:0] a1, b1, sum1;
   logic       busy1, done1, cout1, ovf1;

   int checks   = 0;
   int failures = 0;
   int busy_cnt = 0;

   logic [9:0] sb[$];
   logic [2:0] sb1[$];

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_addsub #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} of a +/- b at width w (w <= 8).
   function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
      int unsigned mask, bb, xx, full;
      logic [7:0]  r;
      logic        c, o;
      mask = (32'd1 << w) - 1;
      xx   = {24'd0, x} & mask;
      bb   = {24'd0, y} & mask;
      if (s) bb = ~bb & mask;
      full = xx + bb + {31'd0, s};
      r    = 8'(full & mask);
      c    = full[w];
      o    = (xx[w-1] == bb[w-1]) && (r[w-1] != xx[w-1]);
      return {o, c, r};
   endfunction

   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic s, input bit hold);
      a = x; b = y; sub = s; start = 1'b1;
      sb.push_back(model(8, x, y, s));
      busy_cnt = 0;
      tick();
      if (!hold) start = 1'b0;
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic check_result(input string tag);
      logic [9:0] e;
      e = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
      chk({tag, ".done"}, done, 1'b1);
      chk({tag, ".sum"}, sum, e[7:0]);
      chk({tag, ".cout"}, cout, e[8]);
      chk({tag, ".ovf"}, ovf, e[9]);
   endtask

   task automatic op(input string tag, input logic [7:0] x, input logic [7:0] y, input logic s);
      int n;
      issue(x, y, s, 1'b0);
      wait_done(n);
      chk({tag, ".lat"}, n + 1, 9);
      chk({tag, ".busy"}, busy_cnt, 8);
      check_result(tag);
      tick();
      chk({tag, ".strobe"}, done, 1'b0);
      chk({tag, ".hold"}, sum, model(8, x, y, s) & 10'h0FF);
   endtask

   initial begin
      int         n;
      bit         seen;
      logic [9:0] e;
      logic [7:0] ba[4], bb[4];
      logic       bs[4];
      logic       xa[3], xb[3], xs[3];

      rst = 1'b1; start = 1'b1; sub = 1'b0; a = 8'h35; b = 8'h4A;
      start1 = 1'b1; sub1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
      tick();
      tick();
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.sum", sum, 8'h00);
      chk("rst.cout", cout, 1'b0);
      chk("rst.ovf", ovf, 1'b0);
      chk("rst.busy1", busy1, 1'b0);
      rst = 1'b0; start = 1'b0; start1 = 1'b0;
      tick();
      chk("idle.busy", busy, 1'b0);

      op("add",      8'h35, 8'h4A, 1'b0);
      op("wrap",     8'hFF, 8'h01, 1'b0);
      op("ovf_add",  8'h7F, 8'h01, 1'b0);
      op("ovf_sub",  8'h80, 8'h01, 1'b1);
      op("borrow",   8'h10, 8'h20, 1'b1);
      op("sub_zero", 8'h5A, 8'h00, 1'b1);
      op("zero",     8'h00, 8'h00, 1'b1);

      // start during RUN must not disturb the operation in flight
      issue(8'h12, 8'h34, 1'b0, 1'b0);
      tick();
      tick();
      a = 8'hFF; b = 8'hFF; sub = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n);
      chk("ign.lat", n + 4, 9);
      check_result("ign");
      tick();

      // reset mid-run aborts without a done pulse
      issue(8'hAA, 8'h11, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort.busy", busy, 1'b0);
      chk("abort.sum", sum, 8'h00);
      chk("abort.cout", cout, 1'b0);
      chk("abort.ovf", ovf, 1'b0);
      if (sb.size() > 0) e = sb.pop_front();
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done === 1'b1) seen = 1'b1;
      end
      chk("abort.nodone", seen, 1'b0);

      // back-to-back with start held
      ba = '{8'h35, 8'h7F, 8'h80, 8'h10};
      bb = '{8'h4A, 8'h01, 8'h01, 8'h20};
      bs = '{1'b0, 1'b0, 1'b1, 1'b1};
      start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = ba[i]; b = bb[i]; sub = bs[i];
         sb.push_back(model(8, ba[i], bb[i], bs[i]));
         tick();
         if (i == 3) start = 1'b0;
         wait_done(n);
         chk($sformatf("b2b%0d.lat", i), n + 1, 9);
         check_result($sformatf("b2b%0d", i));
      end
      tick();
      chk("b2b.end", done, 1'b0);

      // WIDTH=1 instance
      xa = '{1'b1, 1'b1, 1'b0};
      xb = '{1'b1, 1'b1, 1'b1};
      xs = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         a1 = xa[i]; b1 = xb[i]; sub1 = xs[i]; start1 = 1'b1;
         e = model(1, {7'd0, xa[i]}, {7'd0, xb[i]}, xs[i]);
         sb1.push_back({e[9], e[8], e[0]});
         tick();
         start1 = 1'b0;
         chk($sformatf("w1_%0d.busy", i), busy1, 1'b1);
         n = 0;
         while (done1 !== 1'b1 && n < 10) begin
            tick();
            n++;
         end
         chk($sformatf("w1_%0d.lat", i), n + 1, 2);
         e = {7'd0, sb1.pop_front()};
         chk($sformatf("w1_%0d.sum", i), sum1, e[0]);
         chk($sformatf("w1_%0d.cout", i), cout1, e[1]);
         chk($sformatf("w1_%0d.ovf", i), ovf1, e[2]);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the lab board datapath. It is the sequential successor to the fixed 1- and 2-bit combinational adders. A single full-adder cell and a carry flip-flop process one operand bit per clock, LSB first, for a WIDTH-bit result. Operands are captured on a start pulse, and the block reports sum, carry-out and signed overflow with a one-cycle done strobe. It sits between the switch/operand registers and the LED/display drivers.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- sub  input  1  mode, sampled with start; 0 = A+B, 1 = A−B.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle strobe: result outputs just updated.
- sum  output  WIDTH  result, held until the next done.
- cout  output  1  final carry; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement overflow of the last result.

## Operation
- States: IDLE, RUN, DONE; the encoding lives in the shared package.
- IDLE or DONE with start=1 is an accept:
  - latch a into opA and (sub ? ~b : b) into opB;
  - set carry flip-flop = sub and bit index = 0;
  - go to RUN.
- RUN, each cycle:
  - full-adder cell takes opA[0], opB[0] and carry;
  - its sum bit shifts into the MSB of the shift register (shift right);
  - opA and opB shift right, carry ← cell carry-out, index increments.
  - Before the MSB step, the cell's carry-in (carry into MSB) is captured.
- When index reaches WIDTH−1, that step completes and the block goes to DONE.
- DONE (one cycle):
  - sum ← shift register, cout ← carry, ovf ← carry-into-MSB XOR carry;
  - done=1;
  - next state IDLE, or RUN if start=1 (back-to-back accept).
- start while in RUN is ignored. No queuing and no error flag.
- a, b and sub are don't-care except in the accept cycle.
- WIDTH=1: RUN lasts one cycle. ovf = carry-in XOR carry-out of the single step.
- Subtract: A + ~B + 1.
  - A−0 gives cout=1.
  - 0−0 gives sum 0, cout=1, ovf=0.
- Unsigned interpretation: cout is the carry (add) or not-borrow (sub). Signed interpretation: ovf.

## Timing
- Reset values:
  - state IDLE; busy=0, done=0;
  - sum=0, cout=0, ovf=0;
  - internal registers 0.
- rst overrides everything, including start in the same cycle.
- rst mid-RUN aborts the operation. No done pulse occurs, and sum/cout/ovf return to 0.
- Sequence for start accepted at edge k:
  - busy=1 in the cycles after edges k … k+WIDTH−1 (WIDTH cycles);
  - done=1 and new sum/cout/ovf visible after edge k+WIDTH;
  - latency start→done is WIDTH+1 cycles counting the accept cycle.
- busy=0 in the DONE cycle, so a start asserted then is accepted.
- Back-to-back throughput is one result per WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode constants MODE_ADD=0 and MODE_SUB=1.
- Index counter width is $clog2(WIDTH) with a minimum of 1, computed locally.
- One sub-module: the existing full_adder cell (A, B, C → Sum, Cout), instantiated once as the serial bit slice.
- Target is roughly 150–250 lines of RTL, not counting the package.

## Test plan
All cases use WIDTH=8 unless noted.
- Add, no carry: a=0x35, b=0x4A, sub=0 → after 9 cycles done=1, sum=0x7F, cout=0, ovf=0; busy high exactly 8 cycles.
- Carry wrap: a=0xFF, b=0x01, add → sum=0x00, cout=1, ovf=0.
- Overflow in both modes:
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1;
  - 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Borrow: a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0, ovf=0.
- start/rst control:
  - start pulsed again at cycle 3 of RUN with different operands is ignored, and the result is still the first operation's;
  - rst asserted at cycle 4 of RUN → next cycle busy=0, sum=0, and no done pulse follows.
- Back-to-back and WIDTH=1:
  - start held high gives done every 9 cycles with the correct results;
  - repeat with WIDTH=1: a=1, b=1, add → sum=0, cout=1, ovf=1, done 2 cycles after accept.
